// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter plot port between two drawing clients.
// Owns the full-screen clear sweep run after reset and on request.
module vga_plot_arbiter #(
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_req,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [2:0] c0,
    input  logic [2:0] c1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       clear_done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic [7:0] X_LAST = 8'd159;
    localparam logic [6:0] Y_LAST = 7'd119;
    localparam logic [7:0] X_SIZE = 8'd160;
    localparam logic [6:0] Y_SIZE = 7'd120;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_ARB   = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_cx;
    logic [6:0] r_cy;
    logic       r_last;
    logic       r_done;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_last_pix;

    assign w_last_pix = (r_cx == X_LAST) && (r_cy == Y_LAST);

    // Tie-break on contention: the client not served last wins.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == S_ARB && !clear_req) begin
            if (req0 && (!req1 || r_last)) begin
                w_grant0 = 1'b1;
            end else if (req1) begin
                w_grant1 = 1'b1;
            end
        end
    end

    // The clear_done cycle still counts as clearing, so busy
    // only drops once the final pixel has been presented.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_CLEAR: if (r_done) w_state_nx = S_ARB;
            S_ARB:   if (clear_req) w_state_nx = S_CLEAR;
            default: w_state_nx = S_CLEAR;
        endcase
    end

    assign ack0       = w_grant0;
    assign ack1       = w_grant1;
    assign busy       = (r_state == S_CLEAR);
    assign clear_done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx       <= '0;
            r_cy       <= '0;
            r_last     <= 1'b1;
            r_done     <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            if (!r_done) begin
                vga_x      <= r_cx;
                vga_y      <= r_cy;
                vga_colour <= CLEAR_COLOUR;
                vga_plot   <= 1'b1;
                if (w_last_pix) begin
                    r_cx   <= '0;
                    r_cy   <= '0;
                    r_done <= 1'b1;
                end else if (r_cy == Y_LAST) begin
                    r_cy <= '0;
                    r_cx <= r_cx + 8'd1;
                end else begin
                    r_cy <= r_cy + 7'd1;
                end
            end else begin
                r_done   <= 1'b0;
                vga_plot <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
            if (w_grant0) begin
                vga_x      <= x0;
                vga_y      <= y0;
                vga_colour <= c0;
                vga_plot   <= (x0 < X_SIZE) && (y0 < Y_SIZE);
                r_last     <= 1'b0;
            end else if (w_grant1) begin
                vga_x      <= x1;
                vga_y      <= y1;
                vga_colour <= c1;
                vga_plot   <= (x1 < X_SIZE) && (y1 < Y_SIZE);
                r_last     <= 1'b1;
            end else begin
                vga_plot <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: a reference model predicts
// acks and plotted pixels; a monitor pops and compares each plot.
module tb_vga_plot_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_req;
    logic       req0, req1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] c0, c1;
    logic       ack0, ack1, busy, clear_done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    vga_plot_arbiter #(.CLEAR_COLOUR(3'b000)) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
        .req0(req0), .req1(req1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .c0(c0), .c1(c1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .clear_done(clear_done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         cyc;
        bit         done;
    } pix_t;

    pix_t q[$];
    pix_t me;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    // model state
    bit   mode_clear;
    int   clr_cnt;
    int   clr_base;
    int   last;
    int   g;
    logic s_ack0, s_ack1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // Monitor: every plot must match the oldest expected pixel.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (vga_plot) begin
                if (q.size() == 0) begin
                    chk("unexpected_plot", {vga_x, vga_y, vga_colour}, 0);
                end else begin
                    me = q.pop_front();
                    chk("plot_cycle", cyc, me.cyc);
                    chk("plot_pixel", {vga_x, vga_y, vga_colour},
                        {me.x, me.y, me.c});
                    chk("clear_done", clear_done, me.done);
                end
            end else begin
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    me = q.pop_front();
                    chk("plot_missing", vga_plot, 1);
                end
                chk("clear_done_idle", clear_done, 0);
            end
        end
    end

    task automatic start_clear(input int s);
        int k;
        k = 0;
        for (int x = 0; x < 160; x++) begin
            for (int y = 0; y < 120; y++) begin
                q.push_back('{x[7:0], y[6:0], 3'b000, s + 1 + k,
                              k == 19199});
                k++;
            end
        end
        mode_clear = 1;
        clr_cnt    = 19201;
        clr_base   = s;
    endtask

    // One cycle: inputs already driven at the preceding negedge.
    task automatic step();
        #1;
        s_ack0 = ack0;
        s_ack1 = ack1;
        g = -1;
        if (mode_clear) begin
            chk("ack0_in_clear", ack0, 0);
            chk("ack1_in_clear", ack1, 0);
            chk("busy_in_clear", busy, 1);
            clr_cnt--;
            if (clr_cnt == 0) mode_clear = 0;
        end else begin
            chk("busy_in_arb", busy, 0);
            if (clear_req) begin
                chk("ack0_on_clear_req", ack0, 0);
                chk("ack1_on_clear_req", ack1, 0);
                start_clear(cyc + 1);
            end else begin
                if (req0 && req1) g = (last == 0) ? 1 : 0;
                else if (req0) g = 0;
                else if (req1) g = 1;
                chk("ack0", ack0, g == 0);
                chk("ack1", ack1, g == 1);
                if (g == 0) begin
                    last = 0;
                    if (x0 < 160 && y0 < 120)
                        q.push_back('{x0, y0, c0, cyc + 1, 0});
                end else if (g == 1) begin
                    last = 1;
                    if (x1 < 160 && y1 < 120)
                        q.push_back('{x1, y1, c1, cyc + 1, 0});
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_x"}, vga_x, 0);
        chk({tag, "_y"}, vga_y, 0);
        chk({tag, "_colour"}, vga_colour, 0);
        chk({tag, "_plot"}, vga_plot, 0);
        chk({tag, "_acks"}, {ack0, ack1}, 0);
        chk({tag, "_clear_done"}, clear_done, 0);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic release_and_clear();
        @(negedge clk);
        rst_n = 1'b1;
        last  = 1;
        start_clear(cyc);
        while (mode_clear) step();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; clear_req = 0; req0 = 0; req1 = 0;
        x0 = 0; x1 = 0; y0 = 0; y1 = 0; c0 = 0; c1 = 0;
        mode_clear = 0; last = 1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        release_and_clear();

        // contention: strict alternation starting with client 0
        req0 = 1; x0 = 8'd20; y0 = 7'd30; c0 = 3'd1;
        req1 = 1; x1 = 8'd40; y1 = 7'd50; c1 = 3'd2;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("alt_ack1", s_ack1, i % 2);
        end
        req0 = 0; req1 = 0;
        step();

        // single request
        req0 = 1; x0 = 8'd10; y0 = 7'd6; c0 = 3'b101;
        step();
        req0 = 0;
        step();
        step();

        // out-of-range pixel is acked but dropped
        req1 = 1; x1 = 8'd160; y1 = 7'd5; c1 = 3'd7;
        step();
        chk("oor_ack1", s_ack1, 1);
        req1 = 0;
        step();
        step();

        // clear request beats a simultaneous plot request
        clear_req = 1;
        req0 = 1; x0 = 8'd10; y0 = 7'd6; c0 = 3'b101;
        step();
        chk("clear_req_no_ack", s_ack0, 0);
        clear_req = 0;
        while (mode_clear) step();
        step();
        chk("post_clear_ack0", s_ack0, 1);
        req0 = 0;
        step();

        // randomized clients obeying the hold-until-ack rule
        for (int i = 0; i < 1500; i++) begin
            if (!req0 || g == 0) begin
                req0 = 1'($urandom_range(1, 0));
                x0 = 8'($urandom_range(169, 0));
                y0 = 7'($urandom_range(127, 0));
                c0 = 3'($urandom_range(7, 0));
            end
            if (!req1 || g == 1) begin
                req1 = 1'($urandom_range(1, 0));
                x1 = 8'($urandom_range(169, 0));
                y1 = 7'($urandom_range(127, 0));
                c1 = 3'($urandom_range(7, 0));
            end
            step();
        end
        req0 = 0; req1 = 0;
        step();
        step();

        // async reset in the middle of a clear
        clear_req = 1;
        step();
        clear_req = 0;
        while (cyc < clr_base + 1 + 9600) step();
        #3;
        rst_n = 0;
        #1;
        check_reset_vals("async_reset");
        q.delete();
        mode_clear = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("held_reset");
        release_and_clear();

        repeat (3) step();
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
